// File: rtl/kbd_playback_ctrl.sv
// Keyboard-controlled flash playback sequencer: fetches 32-bit words, emits 16-bit halves per tick.
// Optional PLAYBACK_LOOP_EN: wrap at region ends instead of stopping.
module kbd_playback_ctrl #(
  parameter int unsigned       ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_d,
  input  logic              key_e,
  input  logic              key_b,
  input  logic              key_f,
  input  logic              key_r,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [15:0]       audio_data,
  output logic              audio_valid,
  output logic              playing,
  output logic              dir_fwd
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWaitData, StH0, StH1, StAdvance
  } state_e;

  localparam int unsigned KeyF = 0;
  localparam int unsigned KeyB = 1;
  localparam int unsigned KeyE = 2;
  localparam int unsigned KeyD = 3;
  localparam int unsigned KeyR = 4;

  state_e            r_state, w_state_nxt;
  logic [4:0]        r_keys;
  logic [4:0]        w_keys, w_edge;
  logic              r_playing, w_playing_nxt;
  logic              r_dir_fwd, w_dir_fwd_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [15:0]       r_audio_data, w_audio_data_nxt;
  logic              r_audio_valid, w_audio_valid_nxt;
  logic              r_restart_pend, w_restart_pend_nxt;
  logic [31:0]       r_word, w_word_nxt;
  logic              r_word_dir, w_word_dir_nxt;
  logic              w_at_end;
  logic [ADDR_W-1:0] w_start_addr;

  assign w_keys = {key_r, key_d, key_e, key_b, key_f};
  assign w_edge = w_keys & ~r_keys;

  assign w_at_end     = r_dir_fwd ? (r_addr == LAST_ADDR) : (r_addr == '0);
  assign w_start_addr = r_dir_fwd ? '0 : LAST_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_keys         <= '0;
      r_playing      <= 1'b0;
      r_dir_fwd      <= 1'b1;
      r_addr         <= '0;
      r_audio_data   <= '0;
      r_audio_valid  <= 1'b0;
      r_restart_pend <= 1'b0;
      r_word         <= '0;
      r_word_dir     <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_keys         <= w_keys;
      r_playing      <= w_playing_nxt;
      r_dir_fwd      <= w_dir_fwd_nxt;
      r_addr         <= w_addr_nxt;
      r_audio_data   <= w_audio_data_nxt;
      r_audio_valid  <= w_audio_valid_nxt;
      r_restart_pend <= w_restart_pend_nxt;
      r_word         <= w_word_nxt;
      r_word_dir     <= w_word_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_playing_nxt      = r_playing;
    w_dir_fwd_nxt      = r_dir_fwd;
    w_addr_nxt         = r_addr;
    w_audio_data_nxt   = r_audio_data;
    w_audio_valid_nxt  = 1'b0;
    w_restart_pend_nxt = r_restart_pend;
    w_word_nxt         = r_word;
    w_word_dir_nxt     = r_word_dir;

    // R never touches playing, so R+D still pauses.
    if (w_edge[KeyD]) begin
      w_playing_nxt = 1'b0;
    end else if (w_edge[KeyE]) begin
      w_playing_nxt = 1'b1;
    end

    if (w_edge[KeyF] && !w_edge[KeyB]) begin
      w_dir_fwd_nxt = 1'b1;
    end else if (w_edge[KeyB] && !w_edge[KeyF]) begin
      w_dir_fwd_nxt = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (r_playing) w_state_nxt = StFetch;
      end
      StFetch: begin
        if (!flash_waitrequest) w_state_nxt = StWaitData;
      end
      StWaitData: begin
        if (flash_readdatavalid) begin
          if (r_restart_pend) begin
            w_state_nxt = StAdvance;
          end else begin
            w_word_nxt     = flash_readdata;
            w_word_dir_nxt = r_dir_fwd;
            w_state_nxt    = StH0;
          end
        end
      end
      StH0: begin
        if (r_restart_pend) begin
          w_state_nxt = StAdvance;
        end else if (sample_tick && r_playing) begin
          w_audio_data_nxt  = r_word_dir ? r_word[15:0] : r_word[31:16];
          w_audio_valid_nxt = 1'b1;
          w_state_nxt       = StH1;
        end
      end
      StH1: begin
        if (r_restart_pend) begin
          w_state_nxt = StAdvance;
        end else if (sample_tick && r_playing) begin
          w_audio_data_nxt  = r_word_dir ? r_word[31:16] : r_word[15:0];
          w_audio_valid_nxt = 1'b1;
          w_state_nxt       = StAdvance;
        end
      end
      StAdvance: begin
        w_state_nxt = StFetch;
        if (r_restart_pend) begin
          w_addr_nxt         = w_start_addr;
          w_restart_pend_nxt = 1'b0;
        end else if (w_at_end) begin
          // The wrap target and the stop target are both the start of the current direction.
          w_addr_nxt = w_start_addr;
`ifndef PLAYBACK_LOOP_EN
          w_playing_nxt = 1'b0;
          w_state_nxt   = StIdle;
`endif
        end else if (r_dir_fwd) begin
          w_addr_nxt = r_addr + 1'b1;
        end else begin
          w_addr_nxt = r_addr - 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // A fresh R edge wins over the clear in StAdvance so it is never lost.
    if (w_edge[KeyR]) w_restart_pend_nxt = 1'b1;
  end

  assign flash_read  = (r_state == StFetch);
  assign flash_addr  = r_addr;
  assign audio_data  = r_audio_data;
  assign audio_valid = r_audio_valid;
  assign playing     = r_playing;
  assign dir_fwd     = r_dir_fwd;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Bench for kbd_playback_ctrl: flash responder, sample scoreboard and directed/random scenarios.
// Honours PLAYBACK_LOOP_EN the same way as the design.
module tb_kbd_playback_ctrl;

  localparam int unsigned AW = 23;
  localparam logic [AW-1:0] LAST = 23'h7FFFF;
  localparam logic [4:0] KF = 5'b00001;
  localparam logic [4:0] KB = 5'b00010;
  localparam logic [4:0] KE = 5'b00100;
  localparam logic [4:0] KD = 5'b01000;
  localparam logic [4:0] KR = 5'b10000;
`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    keys;
  logic          key_d, key_e, key_b, key_f, key_r;
  logic          sample_tick;
  logic          flash_read;
  logic [AW-1:0] flash_addr;
  logic          flash_waitrequest;
  logic          flash_readdatavalid;
  logic [31:0]   flash_readdata;
  logic [15:0]   audio_data;
  logic          audio_valid;
  logic          playing;
  logic          dir_fwd;

  assign key_f = keys[0];
  assign key_b = keys[1];
  assign key_e = keys[2];
  assign key_d = keys[3];
  assign key_r = keys[4];

  kbd_playback_ctrl #(
    .ADDR_W    (AW),
    .LAST_ADDR (LAST)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .key_d               (key_d),
    .key_e               (key_e),
    .key_b               (key_b),
    .key_f               (key_f),
    .key_r               (key_r),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_addr          (flash_addr),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid),
    .playing             (playing),
    .dir_fwd             (dir_fwd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ws_cfg = -1;
  int lat_cfg = 1;
  int rdv_cnt = 0;
  int acc_cnt = 0;
  int addr_err = 0;
  int read_cycles = 0;
  logic [15:0]   got_q[$];
  logic [AW-1:0] acc_q[$];
  logic          prev_read = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    if (a == '0) return 32'hAAAA5555;
    return {16'hC3A5 ^ a[15:0] ^ {a[22:16], 9'h000}, 16'h1234 + a[15:0]};
  endfunction

  // Next word address after finishing word a; stop is set when playback must halt.
  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input logic fwd,
                                               output logic stop);
    stop = 1'b0;
    if (fwd) begin
      if (a == LAST) begin
        stop = !LOOP;
        return '0;
      end
      return a + 1'b1;
    end
    if (a == '0) begin
      stop = !LOOP;
      return LAST;
    end
    return a - 1'b1;
  endfunction

  always @(negedge clk) begin
    if (audio_valid) got_q.push_back(audio_data);
    if (flash_read) read_cycles++;
    if (flash_read && !flash_waitrequest) begin
      acc_q.push_back(flash_addr);
      acc_cnt++;
    end
    if (flash_read && prev_read && flash_addr !== prev_addr) addr_err++;
    prev_read = flash_read;
    prev_addr = flash_addr;
  end

  // Flash responder: waitrequest stretch, then readdatavalid after lat_cfg cycles.
  initial begin
    int n;
    logic [AW-1:0] a;
    flash_waitrequest   = 1'b1;
    flash_readdatavalid = 1'b0;
    flash_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      flash_readdatavalid = 1'b0;
      flash_readdata      = $urandom;
      if (flash_read && !reset) begin
        n = (ws_cfg < 0) ? int'($urandom_range(0, 3)) : ws_cfg;
        repeat (n) begin @(posedge clk); #1; flash_readdata = $urandom; end
        a = flash_addr;
        flash_waitrequest = 1'b0;
        @(posedge clk); #1;
        flash_waitrequest = 1'b1;
        repeat (lat_cfg) begin @(posedge clk); #1; end
        flash_readdatavalid = 1'b1;
        flash_readdata      = data_of(a);
        rdv_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic key_pulse(input logic [4:0] m);
    keys = m;
    step();
    keys = '0;
    step();
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys = '0;
    sample_tick = 1'b0;
    repeat (15) step();
    reset = 1'b0;
    step();
    got_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_rdv(input int target, input string name);
    int n = 0;
    while (rdv_cnt < target && n < 300) begin step(); n++; end
    if (rdv_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, read data count %0d want %0d", name, rdv_cnt, target);
    end
    step(); step();
  endtask

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target && n < 300) begin step(); n++; end
    if (acc_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s: timeout, accepted reads %0d want %0d", name, acc_cnt, target);
    end
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (!flash_read && n < 300) begin step(); n++; end
    if (!flash_read) begin
      checks++; errors++;
      $display("FAIL %s: timeout, flash_read never asserted", name);
    end
  endtask

  task automatic play_samples(input int target, input string name);
    int tries = 0;
    while (got_q.size() < target && tries < 400) begin
      tick();
      repeat ($urandom_range(0, 2)) step();
      tries++;
    end
    if (got_q.size() < target) begin
      checks++; errors++;
      $display("FAIL %s: got %0d samples want %0d", name, got_q.size(), target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", playing); end
    checks++; if (dir_fwd !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", dir_fwd); end
    checks++; if (flash_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", flash_addr); end
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", flash_read); end
    checks++; if (audio_data !== 16'h0) begin errors++; $display("FAIL reset_audio: got %h want 0", audio_data); end
    checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", audio_valid); end
  endtask

  task automatic test_first_word();
    int base;
    do_reset();
    ws_cfg = 2;
    base = rdv_cnt;
    key_pulse(KE);
    wait_rdv(base + 1, "first_rdv");
    checks++;
    if (acc_q.size() != 1 || acc_q[0] !== '0) begin
      errors++; $display("FAIL first_addr: %0d reads, first %h, want one read at 0", acc_q.size(), acc_q[0]);
    end
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== 16'h5555) begin
      errors++; $display("FAIL first_h0: valid=%b data=%h want 1/5555", audio_valid, audio_data);
    end
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== 16'hAAAA) begin
      errors++; $display("FAIL first_h1: valid=%b data=%h want 1/AAAA", audio_valid, audio_data);
    end
    @(negedge clk);
    checks++;
    if (audio_valid !== 1'b0 || audio_data !== 16'hAAAA) begin
      errors++; $display("FAIL first_hold: valid=%b data=%h want 0/AAAA", audio_valid, audio_data);
    end
    wait_read("first_next");
    checks++; if (flash_addr !== 23'd1) begin errors++; $display("FAIL first_next_addr: got %h want 1", flash_addr); end
    ws_cfg = -1;
  endtask

  task automatic test_backward_zero();
    int base, rc;
    do_reset();
    key_pulse(KB);
    checks++; if (dir_fwd !== 1'b0) begin errors++; $display("FAIL bwd_dir: got %b want 0", dir_fwd); end
    base = rdv_cnt;
    key_pulse(KE);
    wait_rdv(base + 1, "bwd_rdv");
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== 16'hAAAA) begin
      errors++; $display("FAIL bwd_h0: valid=%b data=%h want 1/AAAA", audio_valid, audio_data);
    end
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== 16'h5555) begin
      errors++; $display("FAIL bwd_h1: valid=%b data=%h want 1/5555", audio_valid, audio_data);
    end
`ifdef PLAYBACK_LOOP_EN
    wait_read("bwd_wrap");
    checks++; if (flash_addr !== LAST) begin errors++; $display("FAIL bwd_wrap_addr: got %h want %h", flash_addr, LAST); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL bwd_wrap_play: got %b want 1", playing); end
`else
    rc = read_cycles;
    repeat (10) step();
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL bwd_stop_play: got %b want 0", playing); end
    checks++; if (flash_addr !== LAST) begin errors++; $display("FAIL bwd_stop_addr: got %h want %h", flash_addr, LAST); end
    checks++; if (read_cycles != rc) begin errors++; $display("FAIL bwd_stop_read: %0d read cycles want 0", read_cycles - rc); end
    key_pulse(KE);
    wait_read("bwd_replay");
    checks++; if (flash_addr !== LAST) begin errors++; $display("FAIL bwd_replay_addr: got %h want %h", flash_addr, LAST); end
`endif
  endtask

  task automatic test_pause();
    int base;
    do_reset();
    lat_cfg = 8;
    base = rdv_cnt;
    key_pulse(KE);
    wait_acc(acc_cnt + 1, "pause_acc");
    key_pulse(KD);
    wait_rdv(base + 1, "pause_rdv");
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL pause_tick%0d: valid=%b want 0", i, audio_valid); end
    end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL pause_play: got %b want 0", playing); end
    key_pulse(KE);
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== 16'h5555) begin
      errors++; $display("FAIL pause_resume: valid=%b data=%h want 1/5555", audio_valid, audio_data);
    end
    lat_cfg = 1;
  endtask

  task automatic test_restart();
    int n0, ac;
    logic [31:0] d;
    logic [15:0] exp;
    logic [AW-1:0] a;
    do_reset();
    key_pulse(KE);
    play_samples(33, "rst_play");
    for (int i = 0; i < 33 && i < got_q.size(); i++) begin
      a = AW'(i / 2);
      d = data_of(a);
      exp = (i % 2 == 0) ? d[15:0] : d[31:16];
      checks++; if (got_q[i] !== exp) begin errors++; $display("FAIL rst_seq%0d: got %h want %h", i, got_q[i], exp); end
    end
    n0 = got_q.size();
    key_pulse(KR);
    wait_read("rst_fetch");
    checks++; if (got_q.size() != n0) begin errors++; $display("FAIL rst_novalid: %0d extra samples want 0", got_q.size() - n0); end
    checks++; if (flash_addr !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", flash_addr); end
    play_samples(n0 + 3, "rst_replay");
    d = data_of(23'd1);
    if (got_q.size() >= n0 + 3) begin
      checks++; if (got_q[n0] !== 16'h5555) begin errors++; $display("FAIL rst_r0: got %h want 5555", got_q[n0]); end
      checks++; if (got_q[n0+1] !== 16'hAAAA) begin errors++; $display("FAIL rst_r1: got %h want AAAA", got_q[n0+1]); end
      checks++; if (got_q[n0+2] !== d[15:0]) begin errors++; $display("FAIL rst_r2: got %h want %h", got_q[n0+2], d[15:0]); end
    end
    n0 = got_q.size();
    ac = acc_cnt;
    key_pulse(KR | KD);
    wait_acc(ac + 1, "rstd_acc");
    repeat (6) step();
    checks++; if (acc_q[$] !== '0) begin errors++; $display("FAIL rstd_addr: got %h want 0", acc_q[$]); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL rstd_play: got %b want 0", playing); end
    checks++; if (got_q.size() != n0) begin errors++; $display("FAIL rstd_novalid: %0d extra samples want 0", got_q.size() - n0); end
  endtask

  task automatic test_end_forward();
    int base, rc;
    logic [31:0] d;
    do_reset();
    key_pulse(KB);
    key_pulse(KR);
    base = rdv_cnt;
    key_pulse(KE);
    wait_rdv(base + 2, "end_rdv");
    checks++; if (acc_q.size() < 2 || acc_q[1] !== LAST) begin errors++; $display("FAIL end_fetch: got %h want %h", acc_q[$], LAST); end
    d = data_of(LAST);
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== d[31:16]) begin
      errors++; $display("FAIL end_h0: valid=%b data=%h want 1/%h", audio_valid, audio_data, d[31:16]);
    end
    key_pulse(KF);
    checks++; if (dir_fwd !== 1'b1) begin errors++; $display("FAIL end_dir: got %b want 1", dir_fwd); end
    tick();
    checks++;
    if (audio_valid !== 1'b1 || audio_data !== d[15:0]) begin
      errors++; $display("FAIL end_h1: valid=%b data=%h want 1/%h", audio_valid, audio_data, d[15:0]);
    end
`ifdef PLAYBACK_LOOP_EN
    wait_read("end_wrap");
    checks++; if (flash_addr !== '0) begin errors++; $display("FAIL end_wrap_addr: got %h want 0", flash_addr); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL end_wrap_play: got %b want 1", playing); end
`else
    rc = read_cycles;
    repeat (10) step();
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL end_stop_play: got %b want 0", playing); end
    checks++; if (flash_addr !== '0) begin errors++; $display("FAIL end_stop_addr: got %h want 0", flash_addr); end
    checks++; if (read_cycles != rc) begin errors++; $display("FAIL end_stop_read: %0d read cycles want 0", read_cycles - rc); end
    key_pulse(KE);
    wait_read("end_replay");
    checks++; if (flash_addr !== '0) begin errors++; $display("FAIL end_replay_addr: got %h want 0", flash_addr); end
`endif
  endtask

  task automatic test_keys();
    do_reset();
    key_pulse(KF | KB);
    checks++; if (dir_fwd !== 1'b1) begin errors++; $display("FAIL keys_fb1: got %b want 1", dir_fwd); end
    key_pulse(KB);
    key_pulse(KF | KB);
    checks++; if (dir_fwd !== 1'b0) begin errors++; $display("FAIL keys_fb0: got %b want 0", dir_fwd); end
    keys = KE;
    repeat (3) step();
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL keys_e_on: got %b want 1", playing); end
    keys = KE | KD;
    step();
    keys = KE;
    repeat (6) step();
    keys = '0;
    step();
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL keys_e_held: got %b want 0", playing); end
  endtask

  task automatic test_reset_abort();
    int rc;
    do_reset();
    lat_cfg = 6;
    key_pulse(KE);
    wait_acc(acc_cnt + 1, "abort_acc");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    rc = read_cycles;
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL abort_play: got %b want 0", playing); end
    checks++; if (flash_read !== 1'b0) begin errors++; $display("FAIL abort_read: got %b want 0", flash_read); end
    repeat (12) step();
    repeat (3) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL abort_audio: %0d samples want 0", got_q.size()); end
    checks++; if (read_cycles != rc) begin errors++; $display("FAIL abort_idle: %0d read cycles want 0", read_cycles - rc); end
    lat_cfg = 1;
  endtask

  task automatic test_random_play();
    logic fwd, f, wd, stop;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [15:0] exp;
    int nw;
    do_reset();
    for (int run = 0; run < 6; run++) begin
      key_pulse(KD);
      fwd = 1'($urandom_range(0, 1));
      key_pulse(fwd ? KF : KB);
      key_pulse(KR);
      got_q.delete();
      key_pulse(KE);
      a = fwd ? '0 : LAST;
      f = fwd;
      nw = int'($urandom_range(3, 7));
      for (int w = 0; w < nw; w++) begin
        wd = f;
        d = data_of(a);
        exp = wd ? d[15:0] : d[31:16];
        play_samples(2 * w + 1, "rnd_h0");
        checks++; if (got_q[$] !== exp) begin errors++; $display("FAIL rnd_r%0d_w%0d_h0: got %h want %h", run, w, got_q[$], exp); end
        if ($urandom_range(0, 3) == 0) begin
          f = !f;
          key_pulse(f ? KF : KB);
        end
        exp = wd ? d[31:16] : d[15:0];
        play_samples(2 * w + 2, "rnd_h1");
        checks++; if (got_q[$] !== exp) begin errors++; $display("FAIL rnd_r%0d_w%0d_h1: got %h want %h", run, w, got_q[$], exp); end
        a = model_next(a, f, stop);
        if (stop) begin
          repeat (4) step();
          checks++; if (playing !== 1'b0) begin errors++; $display("FAIL rnd_r%0d_stop: playing=%b want 0", run, playing); end
          break;
        end
      end
    end
  endtask

  initial begin
    keys = '0;
    sample_tick = 1'b0;
    reset = 1'b1;
    test_reset();
    test_first_word();
    test_backward_zero();
    test_pause();
    test_restart();
    test_end_forward();
    test_keys();
    test_reset_abort();
    test_random_play();
    checks++;
    if (addr_err != 0) begin errors++; $display("FAIL addr_stable: %0d address changes during a request, want 0", addr_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_playback_ctrl.md
Name: kbd_playback_ctrl

Overview:
- Sequences 32-bit flash word reads for audio playback under keyboard control.
- Takes decoded key levels (D, E, B, F, R), reads flash words over a waitrequest/readdatavalid handshake, and emits one 16-bit sample per `sample_tick`.
- Sits between the keyboard decoder, the flash controller and the audio output path.

Parameters:
- ADDR_W, 23, flash word-address width.
- LAST_ADDR, 23'h7FFFF, last word address of the sample region; the first is 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_d  in  1  stop/pause key level
- key_e  in  1  play key level
- key_b  in  1  backward key level
- key_f  in  1  forward key level
- key_r  in  1  restart key level
- sample_tick  in  1  one-cycle pulse at the audio sample rate
- flash_read  out  1  read request
- flash_addr  out  ADDR_W  word address
- flash_waitrequest  in  1  flash not accepting the request
- flash_readdatavalid  in  1  read data valid
- flash_readdata  in  32  read word
- audio_data  out  16  current sample
- audio_valid  out  1  one-cycle pulse when audio_data updates
- playing  out  1  playback running
- dir_fwd  out  1  1 = forward, 0 = backward

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high, on `clk` and `reset`.
  - Reset values: playing=0, dir_fwd=1, flash_addr=0, flash_read=0, audio_data=0, audio_valid=0, restart_pend=0, state=IDLE.
  - Reset asserted mid-transaction aborts everything immediately; later flash responses are ignored until the next FETCH.
- Key edges:
  - Keys are levels. Each key is registered and rising-edge detected, so a held key acts once.
  - Edge priority in one cycle is R > D > E: R sets restart_pend and leaves playing unchanged; D clears playing; E sets playing.
  - F sets dir_fwd=1 and B sets dir_fwd=0. F and B on the same cycle are both ignored.
- States:
  - IDLE: playing=1 -> FETCH.
  - FETCH: flash_read=1 with flash_addr stable. When flash_waitrequest=0 the request is accepted; flash_read drops the next cycle -> WAIT_DATA.
  - WAIT_DATA: on flash_readdatavalid, latch the word and latch word_dir=dir_fwd -> H0. If restart_pend=1, discard the word -> ADVANCE.
  - H0: on sample_tick with playing=1, drive the first half (word_dir ? [15:0] : [31:16]), pulse audio_valid for 1 cycle -> H1.
  - H1: on sample_tick with playing=1, drive the other half, pulse audio_valid -> ADVANCE.
  - ADVANCE (1 cycle):
    - If restart_pend: flash_addr = dir_fwd ? 0 : LAST_ADDR, and clear restart_pend.
    - Otherwise step flash_addr by +1 or -1 according to dir_fwd, with the end rules below.
    - Then -> FETCH.
- Pause:
  - An in-flight flash transaction always completes; FETCH and WAIT_DATA are never abandoned.
  - While playing=0, sample_tick is ignored in H0/H1, so the block holds there. It resumes in place on E.
- Restart:
  - In H0/H1, restart_pend jumps to ADVANCE the next cycle with no audio_valid.
  - In FETCH/WAIT_DATA it is handled as described for WAIT_DATA.
- Direction:
  - A direction change takes effect at the next ADVANCE.
  - Half order follows word_dir, so the current word finishes in its original order.
- audio_data holds its value between pulses.
- Latency:
  - tick in H0 -> audio_valid on the next cycle.
  - ADVANCE -> flash_read asserted the next cycle.

Optional Feature:
- Macro: PLAYBACK_LOOP_EN.
- Defined: at an end address, ADVANCE wraps. Forward LAST_ADDR -> 0; backward 0 -> LAST_ADDR. Playback continues.
- Undefined: at an end address, ADVANCE clears playing, sets flash_addr to the start for the current direction (0 forward, LAST_ADDR backward), then -> IDLE. E replays from the start.

Test Plan:
- Reset, key_e edge, flash returns 32'hAAAA5555 after 2 waitrequest cycles -> flash_addr=0 held during the request. The next two ticks give audio_data 16'h5555 then 16'hAAAA, one audio_valid each. flash_addr then becomes 1.
- key_b edge, then play from 0 with PLAYBACK_LOOP_EN -> halves come upper then lower, and the next flash_addr is 23'h7FFFF.
- key_d asserted during WAIT_DATA -> data is still captured; no audio_valid for 5 ticks. key_e -> the next tick outputs the held first half.
- key_r in H1 at address 0x10 (forward) -> no audio_valid, ADVANCE sets flash_addr=0, FETCH follows. key_r with key_d on the same cycle -> restart happens and playing=0.
- key_f and key_b on the same cycle -> dir_fwd unchanged. key_e held high for 10 cycles -> a single play action.
- Without PLAYBACK_LOOP_EN, forward at LAST_ADDR -> after H1, playing=0, flash_addr=0, state IDLE, and no flash_read until key_e.
